// File: rtl/banner_text_ctrl.sv
// banner_text_ctrl: frame-synchronous scheduler for the on-screen text banner.
// Message requests arrive over a valid/ready handshake, wait in a one-entry
// pending register and take effect only on frame_tick, so the banner never
// changes mid-frame. Each message is timed in frames (0 = persistent). For
// every scanned pixel a registered glyph code and glyph origin are produced
// for the per-character glyph units.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse at start of vertical blank
//   req_valid/ready   request handshake (accepted when valid && ready)
//   req_msg           0 "PONG", 1 "L WINS", 2 "R WINS", 3 "PAUSE"
//   req_frames        display duration in frames, 0 = persistent
//   req_clear         request blanks the banner
//   x, y              current pixel column/row
//   char_code         glyph select for the pixel's slot (1-cycle latency)
//   char_x, char_y    glyph origin for the slot
//   char_active       pixel lies in a non-blank slot of the visible banner
//   busy              a message is being shown
//
// Optional feature: define BANNER_BLINK_EN to blink the banner with a
// half-period of 2^BLINK_SHIFT frames (only char_active is gated).

module banner_text_ctrl #(
    parameter int unsigned BASE_X     = 192,
    parameter int unsigned BASE_Y     = 220,
    parameter int unsigned PITCH_LOG2 = 5,
    parameter int unsigned CHAR_H     = 40
`ifdef BANNER_BLINK_EN
    , parameter int unsigned BLINK_SHIFT = 4
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_msg,
    input  logic [7:0]  req_frames,
    input  logic        req_clear,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [3:0]  char_code,
    output logic [31:0] char_x,
    output logic [31:0] char_y,
    output logic        char_active,
    output logic        busy
);

    localparam int unsigned MSG_W  = 2;
    localparam int unsigned FRM_W  = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned CMP_W  = 11;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned BOX_W  = 1 << (SLOT_W + PITCH_LOG2);

    typedef enum logic {IDLE, SHOW} state_t;

    typedef struct packed {
        logic [MSG_W-1:0] msg;
        logic [FRM_W-1:0] frames;
        logic             clear;
    } req_t;

    state_t            state_q, state_d;
    logic              pend_valid_q;
    req_t              pend_q;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [FRM_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              visible;

    assign req_ready = !pend_valid_q;
    assign busy      = (state_q == SHOW);
    assign accept    = req_valid && !pend_valid_q;

    // Message ROM: 8 slots per message, left-aligned, blank-padded.
    function automatic logic [CODE_W-1:0] rom_lookup(input logic [MSG_W-1:0] m,
                                                     input logic [SLOT_W-1:0] s);
        logic [CODE_W-1:0] c;
        c = '0;
        case ({m, s})
            5'b00_000: c = 4'd1;
            5'b00_001: c = 4'd2;
            5'b00_010: c = 4'd3;
            5'b00_011: c = 4'd4;
            5'b01_000: c = 4'd5;
            5'b01_010: c = 4'd10;
            5'b01_011: c = 4'd11;
            5'b01_100: c = 4'd3;
            5'b01_101: c = 4'd13;
            5'b10_000: c = 4'd9;
            5'b10_010: c = 4'd10;
            5'b10_011: c = 4'd11;
            5'b10_100: c = 4'd3;
            5'b10_101: c = 4'd13;
            5'b11_000: c = 4'd1;
            5'b11_001: c = 4'd14;
            5'b11_010: c = 4'd15;
            5'b11_011: c = 4'd13;
            5'b11_100: c = 4'd6;
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Pending register; a tick consumes it, so it cannot accept on that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else if (frame_tick && pend_valid_q) begin
            pend_valid_q <= 1'b0;
        end else if (accept) begin
            pend_valid_q <= 1'b1;
            pend_q       <= {req_msg, req_frames, req_clear};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: everything moves on frame_tick only; pending preempts.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (pend_valid_q) begin
                if (pend_q.clear) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHOW;
                    msg_d   = pend_q.msg;
                    cnt_d   = pend_q.frames;
                end
            end else if (state_q == SHOW && cnt_q != '0) begin
                cnt_d = cnt_q - FRM_W'(1);
                if (cnt_q == FRM_W'(1)) begin
                    state_d = IDLE;
                end
            end
        end
    end

`ifdef BANNER_BLINK_EN
    localparam int unsigned BLINK_W = 8;

    logic [BLINK_W-1:0] blink_q, blink_d;

    // Blink phase counter: restarts on message load, advances per shown frame.
    always_comb begin
        blink_d = blink_q;
        if (frame_tick && pend_valid_q && !pend_q.clear) begin
            blink_d = '0;
        end else if (frame_tick && state_q == SHOW) begin
            blink_d = blink_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign visible = !blink_q[BLINK_SHIFT];
`else
    assign visible = 1'b1;
`endif

    // Pixel lookup, compared at 11 bits so x near 1023 cannot wrap into the box.
    logic [CMP_W-1:0]  x_ext, y_ext, offset;
    logic [SLOT_W-1:0] slot;
    logic              in_box;
    logic [CODE_W-1:0] code_c;

    assign x_ext  = {1'b0, x};
    assign y_ext  = {1'b0, y};
    assign offset = x_ext - CMP_W'(BASE_X);
    assign slot   = SLOT_W'(offset >> PITCH_LOG2);
    assign in_box = (x_ext >= CMP_W'(BASE_X)) && (x_ext < CMP_W'(BASE_X + BOX_W)) &&
                    (y_ext >= CMP_W'(BASE_Y)) && (y_ext < CMP_W'(BASE_Y + CHAR_H));
    assign code_c = (in_box && state_q == SHOW) ? rom_lookup(msg_q, slot) : '0;

    // Output pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code   <= '0;
            char_x      <= '0;
            char_y      <= '0;
            char_active <= 1'b0;
        end else begin
            char_code   <= code_c;
            char_x      <= in_box ? (OUT_W'(BASE_X) + (OUT_W'(slot) << PITCH_LOG2)) : '0;
            char_y      <= OUT_W'(BASE_Y);
            char_active <= (code_c != '0) && visible;
        end
    end

endmodule

// File: tb/tb_banner_text_ctrl.sv
// tb_banner_text_ctrl: directed self-checking bench for banner_text_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_banner_text_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_msg;
    logic [7:0]  req_frames;
    logic        req_clear;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  char_code;
    logic [31:0] char_x;
    logic [31:0] char_y;
    logic        char_active;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    banner_text_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_msg     (req_msg),
        .req_frames  (req_frames),
        .req_clear   (req_clear),
        .x           (x),
        .y           (y),
        .char_code   (char_code),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_active (char_active),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pix(input int px, input int py);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
    endtask

    task automatic send_req(input int m, input int f, input logic c);
        @(negedge clk);
        req_valid  = 1'b1;
        req_msg    = 2'(m);
        req_frames = 8'(f);
        req_clear  = c;
        check("send_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; req_valid = 1'b0;
        req_msg = '0; req_frames = '0; req_clear = 1'b0;
        x = '0; y = '0;

        // Reset state
        #12;
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_ready",  32'(req_ready),   32'd1);
        check("rst_active", 32'(char_active), 32'd0);
        check("rst_code",   32'(char_code),   32'd0);
        check("rst_cx",     char_x,           32'd0);
        check("rst_cy",     char_y,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic show: msg0 for 3 frames
        send_req(0, 3, 1'b0);
        check("basic_pending", 32'(req_ready), 32'd0);
        do_tick();
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_ready_free", 32'(req_ready), 32'd1);
        pix(192, 220);
        check("basic_code0", 32'(char_code),   32'd1);
        check("basic_cx0",   char_x,           32'd192);
        check("basic_cy0",   char_y,           32'd220);
        check("basic_act0",  32'(char_active), 32'd1);
        pix(230, 220);
        check("basic_code1", 32'(char_code),   32'd2);
        check("basic_cx1",   char_x,           32'd224);
        pix(320, 221);
        check("basic_code4", 32'(char_code),   32'd0);
        check("basic_act4",  32'(char_active), 32'd0);
        check("basic_cx4",   char_x,           32'd320);
        ticks(2);
        check("basic_busy_2", 32'(busy), 32'd1);
        do_tick();
        check("basic_busy_end", 32'(busy), 32'd0);
        pix(192, 220);
        check("basic_idle_act", 32'(char_active), 32'd0);

        // Request accepted on the tick cycle waits for the next tick
        @(negedge clk);
        req_valid = 1'b1; req_msg = 2'd3; req_frames = 8'd0; req_clear = 1'b0;
        frame_tick = 1'b1;
        check("tacc_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; frame_tick = 1'b0;
        check("tacc_not_applied", 32'(busy),      32'd0);
        check("tacc_pending",     32'(req_ready), 32'd0);
        do_tick();
        check("tacc_applied", 32'(busy), 32'd1);
        pix(256, 230);
        check("pause_code", 32'(char_code),   32'd15);
        check("pause_cx",   char_x,           32'd256);
        check("pause_act",  32'(char_active), 32'd1);

        // Persistent message survives 100 frames
        ticks(100);
        check("persist_busy", 32'(busy), 32'd1);
        pix(288, 230);
        check("persist_code", 32'(char_code), 32'd13);

        // Clear
        send_req(2, 9, 1'b1);
        do_tick();
        check("clear_busy", 32'(busy), 32'd0);
        pix(192, 220);
        check("clear_act0",  32'(char_active), 32'd0);
        check("clear_code0", 32'(char_code),   32'd0);
        pix(256, 230);
        check("clear_act2",  32'(char_active), 32'd0);

        // Back-to-back requests: second stalls until the tick frees the slot
        @(negedge clk);
        req_valid = 1'b1; req_msg = 2'd1; req_frames = 8'd50; req_clear = 1'b0;
        check("hs_first_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("hs_stall0", 32'(req_ready), 32'd0);
        req_msg = 2'd2; req_frames = 8'd5;
        @(negedge clk);
        check("hs_stall1", 32'(req_ready), 32'd0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("hs_busy",        32'(busy),      32'd1);
        check("hs_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("hs_second_held", 32'(req_ready), 32'd0);
        pix(200, 230);
        check("lwins_code", 32'(char_code), 32'd5);
        check("lwins_cx",   char_x,         32'd192);

        // Preemption by msg2
        do_tick();
        pix(200, 230);
        check("rwins_code", 32'(char_code),   32'd9);
        check("rwins_act",  32'(char_active), 32'd1);
        pix(352, 230);
        check("rwins_code5", 32'(char_code), 32'd13);
        check("rwins_cx5",   char_x,         32'd352);

        // Box bounds
        pix(200, 260);
        check("bound_y_act",  32'(char_active), 32'd0);
        check("bound_y_code", 32'(char_code),   32'd0);
        pix(191, 230);
        check("bound_x_act", 32'(char_active), 32'd0);
        check("bound_x_cx",  char_x,           32'd0);
        pix(1023, 230);
        check("bound_xmax_act", 32'(char_active), 32'd0);
        pix(200, 259);
        check("bound_ylast_act", 32'(char_active), 32'd1);

        ticks(4);
        check("preempt_busy4", 32'(busy), 32'd1);
        do_tick();
        check("preempt_busy5", 32'(busy), 32'd0);

        // Persistent msg0, then asynchronous reset mid-SHOW
        send_req(0, 0, 1'b0);
        do_tick();
        pix(192, 220);
        check("pre_rst_act", 32'(char_active), 32'd1);
`ifdef BANNER_BLINK_EN
        ticks(15);
        pix(192, 220);
        check("blink_on15",  32'(char_active), 32'd1);
        do_tick();
        pix(192, 220);
        check("blink_off16", 32'(char_active), 32'd0);
        check("blink_code16", 32'(char_code),  32'd1);
        check("blink_busy16", 32'(busy),       32'd1);
        ticks(15);
        pix(192, 220);
        check("blink_off31", 32'(char_active), 32'd0);
        do_tick();
        pix(192, 220);
        check("blink_on32",  32'(char_active), 32'd1);
`endif
        send_req(1, 5, 1'b0);
        check("pre_rst_pending", 32'(req_ready), 32'd0);
        check("pre_rst_busy",    32'(busy),      32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy),        32'd0);
        check("arst_ready",  32'(req_ready),   32'd1);
        check("arst_active", 32'(char_active), 32'd0);
        check("arst_code",   32'(char_code),   32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
